// File: rtl/progmem_loader.sv
// Loads a big-endian byte-stream program image into progmem, reads it back,
// and releases the CPU from reset only when both checksums match the host's.
module progmem_loader #(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_write_en,
  input  logic [15:0]       mem_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_resetn
);

  typedef enum logic [3:0] {
    IDLE, RX_HI, RX_LO, WRITE, CK_HI, CK_LO, VERIFY, CHECK, DONE, ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   VCNT_END  = (ADDR_W+1)'(NUM_WORDS);
  localparam logic [ADDR_W:0]   VADDR_END = (ADDR_W+1)'(NUM_WORDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   vcnt;
  logic [7:0]        hi;
  logic [15:0]       rx_ck, rd_ck, host_ck;
  logic              xfer, go;

  assign xfer = s_valid & s_ready;
  assign go   = start & ~busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Handshake and status are pure decodes of the state register.
  always_comb begin
    state_nxt    = state;
    s_ready      = 1'b0;
    mem_write_en = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    cpu_resetn   = 1'b0;
    case (state)
      IDLE:   begin busy = 1'b0; if (start) state_nxt = RX_HI; end
      RX_HI:  begin s_ready = 1'b1; if (s_valid) state_nxt = RX_LO; end
      RX_LO:  begin s_ready = 1'b1; if (s_valid) state_nxt = WRITE; end
      WRITE:  begin
        mem_write_en = 1'b1;
        state_nxt    = (idx == IDX_LAST) ? CK_HI : RX_HI;
      end
      CK_HI:  begin s_ready = 1'b1; if (s_valid) state_nxt = CK_LO; end
      CK_LO:  begin s_ready = 1'b1; if (s_valid) state_nxt = VERIFY; end
      VERIFY: if (vcnt == VCNT_END) state_nxt = CHECK;
      CHECK:  state_nxt = (rx_ck == host_ck && rd_ck == host_ck) ? DONE : ERROR;
      DONE:   begin
        busy = 1'b0; done = 1'b1; cpu_resetn = 1'b1;
        if (start) state_nxt = RX_HI;
      end
      ERROR:  begin busy = 1'b0; error = 1'b1; if (start) state_nxt = RX_HI; end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr/mem_din are registers so they hold outside WRITE and VERIFY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx      <= '0;
      vcnt     <= '0;
      hi       <= '0;
      rx_ck    <= '0;
      rd_ck    <= '0;
      host_ck  <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      if (go) begin
        idx   <= '0;
        rx_ck <= '0;
        rd_ck <= '0;
      end
      case (state)
        RX_HI: if (xfer) hi <= s_data;
        RX_LO: if (xfer) begin
          mem_addr <= idx;
          mem_din  <= {hi, s_data};
          rx_ck    <= rx_ck ^ {hi, s_data};
        end
        WRITE: idx <= idx + 1'b1;
        CK_HI: if (xfer) host_ck[15:8] <= s_data;
        CK_LO: if (xfer) begin
          host_ck[7:0] <= s_data;
          vcnt         <= '0;
          mem_addr     <= '0;
        end
        // Read data lags the address by one cycle, so accumulation trails by one.
        VERIFY: begin
          vcnt <= vcnt + 1'b1;
          if (vcnt != '0)       rd_ck    <= rd_ck ^ mem_dout;
          if (vcnt < VADDR_END) mem_addr <= vcnt[ADDR_W-1:0] + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_progmem_loader.sv
// Bench for progmem_loader: table of load scenarios against a progmem model
// and an image/checksum reference computed directly from the stream format.
module tb_progmem_loader;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          resetn, start, s_valid, s_ready;
  logic [7:0]    s_data;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din, mem_dout;
  logic          mem_write_en, busy, done, error, cpu_resetn;

  progmem_loader #(.NUM_WORDS(N), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_write_en(mem_write_en), .mem_dout(mem_dout),
    .busy(busy), .done(done), .error(error), .cpu_resetn(cpu_resetn)
  );

  always #5 clk = ~clk;

  // progmem model with optional read fault on bit 0 of address 5
  logic [15:0] mem [2**AW];
  logic        fault = 1'b0;
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr] ^ ((fault && mem_addr == AW'(5)) ? 16'h0001 : 16'h0000);
  end

  // expected image for the current load
  logic [15:0] img [N];

  // write-stream monitor: each strobe must be the next word in address order
  int wr_total = 0, wr_bad = 0, busy_total = 0, wr_base = 0, widx;
  always @(negedge clk) begin
    if (busy) busy_total++;
    if (mem_write_en) begin
      widx = wr_total - wr_base;
      if (widx >= N || widx < 0) begin
        wr_bad++;
        $display("  extra write #%0d addr=%0d din=%h", widx, mem_addr, mem_din);
      end else if (mem_addr != AW'(widx) || mem_din != img[widx]) begin
        wr_bad++;
        $display("  write #%0d addr=%0d din=%h want addr=%0d din=%h",
                 widx, mem_addr, mem_din, widx, img[widx]);
      end
      wr_total++;
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // present one byte after `gap` idle cycles; returns on the negedge after transfer
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget = 0;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) chk("s_ready_timeout", 64'(budget), 64'd0);
    @(negedge clk);
  endtask

  typedef struct {
    bit fixed;      // 1: 0x1234,0x00FF,0...; 0: random words
    int gap_max;
    bit bad_ck;
    bit flt;
    int poke_word;  // pulse start during RX_LO of this word (-1 none)
    int rst_word;   // assert reset after this word is written (-1 none)
    bit exp_done;
    bit exp_err;
  } vec_t;

  task automatic run_load(input int n, input vec_t v);
    logic [15:0] ck;
    int bb, wb, wbad0, budget;
    for (int i = 0; i < N; i++)
      img[i] = v.fixed ? ((i == 0) ? 16'h1234 : (i == 1) ? 16'h00FF : 16'h0000)
                       : 16'($urandom);
    ck = 16'h0000;
    for (int i = 0; i < N; i++) ck ^= img[i];
    if (v.bad_ck) ck ^= 16'h0001;
    fault   = v.flt;
    wr_base = wr_total;
    wbad0   = wr_bad;
    bb      = busy_total;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("start%0d_status", n), {60'd0, busy, done, error, cpu_resetn}, 64'h8);

    for (int i = 0; i < N; i++) begin
      send_byte(img[i][15:8], v.gap_max == 0 ? 0 : int'($urandom_range(v.gap_max, 0)));
      if (i == v.poke_word) start = 1'b1;
      send_byte(img[i][7:0], v.gap_max == 0 ? 0 : int'($urandom_range(v.gap_max, 0)));
      start = 1'b0;
      if (i == v.rst_word) begin
        s_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk($sformatf("midrst%0d_outs", n),
            {35'd0, s_ready, mem_write_en, busy, done, error, cpu_resetn, mem_addr, mem_din},
            64'd0);
        chk($sformatf("midrst%0d_wrcnt", n), 64'(wr_total - wr_base), 64'(i + 1));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk($sformatf("midrst%0d_idle", n), {61'd0, busy, done, cpu_resetn}, 64'd0);
        return;
      end
    end
    send_byte(ck[15:8], 0);
    send_byte(ck[7:0], 0);
    s_valid = 1'b0;

    budget = 0;
    while (busy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk($sformatf("load%0d_finish", n), 64'(budget < 200), 64'd1);
    chk($sformatf("load%0d_done_err_cpu", n), {61'd0, done, error, cpu_resetn},
        {61'd0, v.exp_done, v.exp_err, v.exp_done});
    chk($sformatf("load%0d_writes", n), 64'(wr_total - wr_base), 64'(N));
    chk($sformatf("load%0d_write_seq", n), 64'(wr_bad - wbad0), 64'd0);
    if (v.gap_max == 0 && v.poke_word < 0)
      chk($sformatf("load%0d_latency", n), 64'(busy_total - bb), 64'(4 * N + 4));
    for (int i = 0; i < N; i++)
      chk($sformatf("load%0d_mem%0d", n, i), 64'(mem[i]), 64'(img[i]));
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 0, 1'b0, 1'b0, -1, -1, 1'b1, 1'b0};  // nominal
    tbl[1] = '{1'b1, 0, 1'b1, 1'b0, -1, -1, 1'b0, 1'b1};  // checksum 0x12CA
    tbl[2] = '{1'b1, 3, 1'b0, 1'b0, -1, -1, 1'b1, 1'b0};  // gaps
    tbl[3] = '{1'b1, 0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b1};  // readback fault
    tbl[4] = '{1'b0, 3, 1'b0, 1'b0,  3, -1, 1'b1, 1'b0};  // start while busy
    tbl[5] = '{1'b1, 0, 1'b0, 1'b0, -1,  7, 1'b0, 1'b0};  // reset mid-load
    tbl[6] = '{1'b0, 0, 1'b0, 1'b0, -1, -1, 1'b1, 1'b0};  // load after reset
    tbl[7] = '{1'b0, 2, 1'b0, 1'b0, -1, -1, 1'b1, 1'b0};  // reload from DONE
    tbl[8] = '{1'b0, 1, 1'b1, 1'b0, -1, -1, 1'b0, 1'b1};  // random, bad checksum

    resetn  = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {35'd0, s_ready, mem_write_en, busy, done, error, cpu_resetn, mem_addr, mem_din}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {60'd0, s_ready, busy, done, cpu_resetn}, 64'd0);

    for (int t = 0; t < 9; t++) begin
      if (t == 7) chk("pre_reload_done", {62'd0, done, cpu_resetn}, 64'h3);
      run_load(t, tbl[t]);
      repeat (2) @(negedge clk);
    end

    // DONE/ERROR are held until the next start
    repeat (5) @(negedge clk);
    chk("error_held", {62'd0, error, done}, 64'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/progmem_loader.md
Name: progmem_loader

Overview:
- Initiator/writer for the progmem port: receives a program image as a byte stream from a host link, writes it into program memory, then reads it back to verify.
- Holds the CPU in reset while loading. Releases the CPU only after the image passes the checksum check.
- Sits between the host/UART byte interface and progmem. It drives progmem's addr, din and write_en, and consumes progmem's dout.

Parameters:
- NUM_WORDS, 16, number of 16-bit program words loaded (one per progmem address).
- ADDR_W, 4, width of mem_addr; requires 2**ADDR_W >= NUM_WORDS.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- s_data  in  8  incoming byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts byte; transfer occurs on the edge where s_valid && s_ready.
- mem_addr  out  ADDR_W  progmem address.
- mem_din  out  16  progmem write data.
- mem_write_en  out  1  progmem write strobe.
- mem_dout  in  16  progmem read data, valid the cycle after mem_addr is presented (synchronous read).
- busy  out  1  high in any state other than IDLE, DONE, ERROR.
- done  out  1  load verified; held until next start.
- error  out  1  checksum/verify mismatch; held until next start.
- cpu_resetn  out  1  CPU reset, active-low; high only in DONE.

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - s_ready, mem_write_en, busy, done, error and cpu_resetn are all 0.
  - mem_addr = 0, mem_din = 0.
  - Internal word index, byte latch and both checksums clear.
- Reset mid-load: the same reset values apply. Progmem contents already written are not cleared, and cpu_resetn stays 0.
- Stream format, all big-endian:
  - NUM_WORDS words, each sent as a high byte then a low byte.
  - Then a 16-bit checksum, high byte then low byte.
  - Checksum = XOR of all NUM_WORDS words.
- States:
  - IDLE: s_ready=0. start -> RX_HI; index, rx checksum (rx_ck) and read checksum (rd_ck) clear.
  - RX_HI: s_ready=1. On transfer, latch the high byte -> RX_LO.
  - RX_LO: s_ready=1. On transfer, form word = {hi, s_data}, rx_ck ^= word -> WRITE.
  - WRITE (exactly 1 cycle):
    - s_ready=0, mem_write_en=1, mem_addr=index, mem_din=word.
    - Then index++ -> RX_HI, or -> CK_HI if index == NUM_WORDS-1.
  - CK_HI / CK_LO: s_ready=1. Latch the host checksum (host_ck) bytes. After CK_LO transfer -> VERIFY with rd index = 0.
  - VERIFY (NUM_WORDS+1 cycles):
    - Cycle k (0..NUM_WORDS-1) drives mem_addr=k, mem_write_en=0.
    - Cycles 1..NUM_WORDS XOR the previous cycle's mem_dout into rd_ck.
    - After the last accumulation -> CHECK.
  - CHECK (1 cycle): if rx_ck == host_ck and rd_ck == host_ck -> DONE, else -> ERROR.
  - DONE: done=1, cpu_resetn=1. start -> clears done, drops cpu_resetn the same edge -> RX_HI (fresh load).
  - ERROR: error=1, cpu_resetn=0. start -> clears error -> RX_HI.
- Latencies and counts:
  - A word is written the cycle after its low byte transfers.
  - A full load with zero stall is 3*NUM_WORDS + 2 stream/write cycles + NUM_WORDS+1 verify cycles + 1 check cycle.
  - Exactly NUM_WORDS write strobes per load, at addresses 0..NUM_WORDS-1 in order, each 1 cycle wide.
- Handshake rules:
  - s_ready is registered state decode. A byte with s_valid=0 is ignored with no state change, so arbitrary gaps are allowed.
  - Bytes offered in IDLE/WRITE/VERIFY/CHECK/DONE/ERROR are not accepted (s_ready=0).
- start while busy is ignored.
- Outside WRITE and VERIFY, mem_addr and mem_din hold their last values.
- mem_write_en is never high outside WRITE.

Test Plan:
- Nominal load:
  - Stimulus: start; word0=0x1234, word1=0x00FF, words 2..15=0x0000, checksum 0x12CB, s_valid continuous.
  - Required: 16 single-cycle writes to addr 0..15 with the correct din, then 17 verify reads, then done=1, cpu_resetn=1, error=0.
  - Progmem readback: addr0=0x1234, addr1=0x00FF.
- Bad checksum: same image with checksum 0x12CA -> all 16 writes occur, then error=1, done=0, cpu_resetn=0.
- Backpressure/gaps:
  - Stimulus: insert 0-3 idle cycles between bytes, and hold s_valid high during WRITE.
  - Required: no byte lost or duplicated, written image is identical to the nominal case, done=1.
- Readback fault: memory model flips bit 0 of addr 5 on read -> rd_ck mismatch -> error=1 although rx_ck == host_ck.
- start while busy and reset mid-load:
  - start pulsed during RX_LO of word 3 -> ignored, load continues normally.
  - resetn asserted after word 7 -> all outputs go to 0 immediately.
  - A following start plus full image -> done=1.
- Reload from DONE: start in DONE -> cpu_resetn falls on that edge, done clears, a second image loads and verifies -> done=1 again.
